// File: rtl/id_issue_ctrl_if.sv
// id_issue_ctrl_if: decode-stage issue handshake, writeback port and scoreboard status bundle
interface id_issue_ctrl_if #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_reg_write;
  logic             ex_ready;
  logic             flush;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic             drain_req;
  logic             cnt_clr;
  logic             issue;
  logic             id_stall;
  logic             drain_done;
  logic [NREG-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] issue_cnt;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_reg_write,
           ex_ready, flush, wb_we, wb_rd, drain_req, cnt_clr,
    input  issue, id_stall, drain_done, busy_mask, stall_cnt, issue_cnt
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_reg_write,
           ex_ready, flush, wb_we, wb_rd, drain_req, cnt_clr,
    output issue, id_stall, drain_done, busy_mask, stall_cnt, issue_cnt
  );
endinterface

// File: rtl/id_issue_ctrl.sv
// id_issue_ctrl: scoreboard hazard check, zero-latency issue decision and drain FSM for decode
module id_issue_ctrl #(
  parameter int NREG      = 32,
  parameter bit BYPASS_WB = 1'b1,
  parameter int CNT_W     = 32
) (
  input logic            clk,
  input logic            reset,
  id_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
  state_e           state_q, state_d;
  logic [NREG-1:0]  busy_q, busy_d, wb_clr, id_set, busy_eff;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, issue_cnt_q, issue_cnt_d;
  logic             drain_done_q, drain_done_d, hazard, issue, id_stall;
  always_comb begin
    wb_clr = '0;
    id_set = '0;
    wb_clr[bus.wb_rd] = bus.wb_we && bus.wb_rd != 5'd0;
    busy_eff = busy_q & ~(BYPASS_WB ? wb_clr : '0);
    busy_eff[0] = 1'b0;
    hazard = (bus.id_use_rs1 && busy_eff[bus.id_rs1]) ||
             (bus.id_use_rs2 && busy_eff[bus.id_rs2]) ||
             (bus.id_reg_write && busy_eff[bus.id_rd]);
    issue = bus.id_valid && bus.ex_ready && !hazard && !bus.flush &&
            state_q == RUN && !bus.drain_req;
    id_stall = bus.id_valid && !issue && !bus.flush;
    id_set[bus.id_rd] = issue && bus.id_reg_write && bus.id_rd != 5'd0;
    // OR-ing the set after the clear makes a same-register set win
    busy_d = (busy_q & ~wb_clr) | id_set;
    state_d = state_q == DONE  ? RUN :
              state_q == DRAIN ? (|busy_d ? DRAIN : DONE) :
              bus.drain_req    ? DRAIN : RUN;
    drain_done_d = state_d == DONE;
    stall_cnt_d = bus.cnt_clr ? '0 : stall_cnt_q + CNT_W'(id_stall && !(&stall_cnt_q));
    issue_cnt_d = bus.cnt_clr ? '0 : issue_cnt_q + CNT_W'(issue);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= RUN;
      busy_q       <= '0;
      drain_done_q <= 1'b0;
      stall_cnt_q  <= '0;
      issue_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      drain_done_q <= drain_done_d;
      stall_cnt_q  <= stall_cnt_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end
  assign bus.issue      = issue;
  assign bus.id_stall   = id_stall;
  assign bus.drain_done = drain_done_q;
  assign bus.busy_mask  = busy_q;
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.issue_cnt  = issue_cnt_q;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb_id_issue_ctrl: bypass and no-bypass controllers driven in lockstep, checked against a spec model
module tb_id_issue_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic id_valid, id_use_rs1, id_use_rs2, id_reg_write, ex_ready, flush, wb_we, drain_req, cnt_clr;
  logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
  int total = 0, bad = 0;
  bit m_known = 1'b0;
  bit [31:0] m_busy [2];
  int m_mode [2];
  int m_sc [2], m_ic [2];
  id_issue_ctrl_if #(.NREG(32), .CNT_W(4)) if_b ();
  id_issue_ctrl_if #(.NREG(32), .CNT_W(4)) if_n ();
  id_issue_ctrl #(.NREG(32), .BYPASS_WB(1'b1), .CNT_W(4)) u_byp (.clk(clk), .reset(reset), .bus(if_b));
  id_issue_ctrl #(.NREG(32), .BYPASS_WB(1'b0), .CNT_W(4)) u_nob (.clk(clk), .reset(reset), .bus(if_n));
  assign {if_b.id_valid, if_n.id_valid} = {2{id_valid}};
  assign {if_b.id_rs1, if_n.id_rs1} = {2{id_rs1}};
  assign {if_b.id_rs2, if_n.id_rs2} = {2{id_rs2}};
  assign {if_b.id_rd, if_n.id_rd} = {2{id_rd}};
  assign {if_b.id_use_rs1, if_n.id_use_rs1} = {2{id_use_rs1}};
  assign {if_b.id_use_rs2, if_n.id_use_rs2} = {2{id_use_rs2}};
  assign {if_b.id_reg_write, if_n.id_reg_write} = {2{id_reg_write}};
  assign {if_b.ex_ready, if_n.ex_ready} = {2{ex_ready}};
  assign {if_b.flush, if_n.flush} = {2{flush}};
  assign {if_b.wb_we, if_n.wb_we} = {2{wb_we}};
  assign {if_b.wb_rd, if_n.wb_rd} = {2{wb_rd}};
  assign {if_b.drain_req, if_n.drain_req} = {2{drain_req}};
  assign {if_b.cnt_clr, if_n.cnt_clr} = {2{cnt_clr}};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model view: instance 0 lets a same-cycle writeback hide its register, instance 1 does not
  function automatic void exp_comb(input int k, output bit iss, output bit stl);
    bit [31:0] vis;
    bit haz;
    vis = m_busy[k];
    if (k == 0 && wb_we) vis[wb_rd] = 1'b0;
    vis[0] = 1'b0;
    haz = (id_use_rs1 && vis[id_rs1]) || (id_use_rs2 && vis[id_rs2]) || (id_reg_write && vis[id_rd]);
    iss = id_valid && ex_ready && !haz && !flush && m_mode[k] == 0 && !drain_req;
    stl = id_valid && !iss && !flush;
  endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit ei, es;
      bit [31:0] nb;
      exp_comb(k, ei, es);
      if (m_known) begin
        chk($sformatf("issue[%0d]", k), k ? if_n.issue : if_b.issue, ei);
        chk($sformatf("id_stall[%0d]", k), k ? if_n.id_stall : if_b.id_stall, es);
        chk($sformatf("drain_done[%0d]", k), k ? if_n.drain_done : if_b.drain_done, m_mode[k] == 2);
        chk($sformatf("busy_mask[%0d]", k), k ? if_n.busy_mask : if_b.busy_mask, m_busy[k]);
        chk($sformatf("stall_cnt[%0d]", k), k ? if_n.stall_cnt : if_b.stall_cnt, m_sc[k]);
        chk($sformatf("issue_cnt[%0d]", k), k ? if_n.issue_cnt : if_b.issue_cnt, m_ic[k]);
      end
      if (!reset) begin
        m_busy[k] = '0; m_mode[k] = 0; m_sc[k] = 0; m_ic[k] = 0;
      end else if (m_known) begin
        nb = m_busy[k];
        if (wb_we) nb[wb_rd] = 1'b0;
        if (ei && id_reg_write) nb[id_rd] = 1'b1;
        nb[0] = 1'b0;
        m_busy[k] = nb;
        m_mode[k] = m_mode[k] == 2 ? 0 : m_mode[k] == 1 ? (nb == 0 ? 2 : 1) : (drain_req ? 1 : 0);
        m_sc[k] = cnt_clr ? 0 : (es && m_sc[k] < 15) ? m_sc[k] + 1 : m_sc[k];
        m_ic[k] = cnt_clr ? 0 : (m_ic[k] + int'(ei)) % 16;
      end
    end
    if (!reset) m_known = 1'b1;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_valid, id_use_rs1, id_use_rs2, id_reg_write, flush, wb_we, drain_req, cnt_clr} = '0;
    {id_rs1, id_rs2, id_rd, wb_rd} = '0;
    ex_ready = 1'b1;
  endtask
  task automatic instr(input int r1, input int r2, input int rd, input bit u1, input bit u2, input bit w);
    id_valid = 1'b1; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
    id_use_rs1 = u1; id_use_rs2 = u2; id_reg_write = w;
  endtask
  task automatic wb(input int r);
    wb_we = 1'b1; wb_rd = 5'(r);
  endtask
  task automatic rnd();
    id_valid = $urandom_range(0, 3) != 0; id_rs1 = 5'($urandom_range(0, 7));
    id_rs2 = 5'($urandom_range(0, 7)); id_rd = 5'($urandom_range(0, 7));
    id_use_rs1 = $urandom_range(0, 1) == 1; id_use_rs2 = $urandom_range(0, 1) == 1;
    id_reg_write = $urandom_range(0, 2) != 0; ex_ready = $urandom_range(0, 4) != 0;
    flush = $urandom_range(0, 9) == 0; wb_we = $urandom_range(0, 2) == 0;
    wb_rd = 5'($urandom_range(0, 7)); drain_req = $urandom_range(0, 19) == 0;
    cnt_clr = $urandom_range(0, 29) == 0;
  endtask
  initial begin
    rnd(); reset = 1'b0;
    tick(); rnd(); tick();
    reset = 1'b1; idle(); #1;
    chk("rst_busy_b", if_b.busy_mask, 0); chk("rst_busy_n", if_n.busy_mask, 0);
    chk("rst_icnt_b", if_b.issue_cnt, 0); chk("rst_done_b", if_b.drain_done, 0);
    chk("rst_scnt_n", if_n.stall_cnt, 0);
    instr(0, 0, 5, 0, 0, 1); #1;
    chk("raw_first_issue", if_b.issue, 1);
    tick();
    instr(5, 0, 0, 1, 0, 0); #1;
    chk("raw_stall_b", if_b.id_stall, 1); chk("raw_noissue_n", if_n.issue, 0);
    chk("raw_busy5", if_b.busy_mask, 32'h20);
    tick();
    chk("raw_scnt", if_b.stall_cnt, 1);
    wb(5); #1;
    chk("raw_byp_issue", if_b.issue, 1); chk("raw_nob_hold", if_n.issue, 0);
    chk("raw_nob_stall", if_n.id_stall, 1);
    tick();
    wb_we = 1'b0; #1;
    chk("raw_nob_late_issue", if_n.issue, 1);
    tick();
    chk("raw_icnt_b", if_b.issue_cnt, 3); chk("raw_scnt_n", if_n.stall_cnt, 2);
    idle(); instr(0, 0, 0, 0, 0, 1); #1;
    chk("x0_issue", if_b.issue, 1);
    tick();
    chk("x0_busy", if_b.busy_mask, 0);
    instr(0, 0, 7, 0, 0, 1); tick();
    chk("waw_busy7", if_n.busy_mask, 32'h80);
    #1; chk("waw_stall_b", if_b.id_stall, 1); chk("waw_stall_n", if_n.id_stall, 1);
    tick();
    wb(7); #1;
    chk("waw_byp_issue", if_b.issue, 1); chk("waw_nob_noissue", if_n.issue, 0);
    tick();
    chk("set_wins_b", if_b.busy_mask, 32'h80); chk("waw_clear_n", if_n.busy_mask, 0);
    wb_we = 1'b0; #1;
    chk("waw_late_n", if_n.issue, 1); chk("waw_restall_b", if_b.id_stall, 1);
    tick();
    idle(); wb(7); tick();
    chk("waw_done", if_b.busy_mask, 0);
    idle(); instr(0, 0, 4, 0, 0, 1); cnt_clr = 1'b1; #1;
    chk("clr_issue", if_b.issue, 1);
    tick();
    chk("clr_icnt", if_b.issue_cnt, 0); chk("clr_scnt", if_n.stall_cnt, 0);
    cnt_clr = 1'b0; instr(0, 4, 6, 0, 1, 1); flush = 1'b1; #1;
    chk("flush_nostall", if_b.id_stall, 0); chk("flush_noissue", if_b.issue, 0);
    tick();
    chk("flush_scnt", if_b.stall_cnt, 0); chk("flush_busy", if_b.busy_mask, 32'h10);
    idle(); wb(4); tick();
    idle(); instr(0, 0, 3, 0, 0, 1); tick();
    instr(0, 0, 9, 0, 0, 1); tick();
    chk("drain_busy", if_b.busy_mask, 32'h208);
    instr(1, 0, 0, 1, 0, 0); drain_req = 1'b1; #1;
    chk("drain_block", if_b.issue, 0); chk("drain_block_n", if_n.issue, 0);
    tick();
    drain_req = 1'b0; wb(3); #1;
    chk("drain_wait0", if_b.drain_done, 0); chk("drain_held", if_b.issue, 0);
    tick();
    wb(9); #1;
    chk("drain_wait1", if_b.drain_done, 0);
    tick();
    wb_we = 1'b0; #1;
    chk("drain_pulse", if_b.drain_done, 1); chk("drain_pulse_n", if_n.drain_done, 1);
    chk("done_block", if_b.issue, 0);
    tick();
    chk("drain_pulse_end", if_b.drain_done, 0); chk("run_again", if_b.issue, 1);
    idle(); drain_req = 1'b1; tick();
    drain_req = 1'b0; #1;
    chk("empty_drain_1", if_b.drain_done, 0);
    tick();
    chk("empty_drain_2", if_b.drain_done, 1);
    tick();
    chk("empty_drain_end", if_b.drain_done, 0);
    instr(0, 0, 2, 0, 0, 1); tick();
    idle(); drain_req = 1'b1; tick();
    drain_req = 1'b0; reset = 1'b0; wb(2); tick();
    reset = 1'b1; idle(); #1;
    chk("rst_drain_nopulse", if_b.drain_done, 0); chk("rst_drain_busy", if_b.busy_mask, 0);
    tick();
    chk("rst_drain_nopulse2", if_n.drain_done, 0);
    cnt_clr = 1'b1; tick();
    cnt_clr = 1'b0; instr(0, 0, 8, 0, 0, 1); tick();
    instr(8, 0, 0, 1, 0, 0); tick(14);
    chk("sat_14", if_b.stall_cnt, 14);
    tick(3);
    chk("sat_15_b", if_b.stall_cnt, 15); chk("sat_15_n", if_n.stall_cnt, 15);
    idle(); wb(8); tick();
    for (int i = 0; i < 300; i++) begin
      rnd(); tick();
    end
    idle(); tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
